mixer_valve_seq: RTL and testbench
==================================

# mixer_valve_seq

Cycle-accurate valve/pump sequencer for one rotary mixer node in the cubic-graph mixer networks. It fills the ring from input port `a`, then from port `b`. It then mixes for a fixed number of peristaltic rotations and drains to output `y` once the downstream mixer is ready. Upstream mixers feed the `*_vld` inputs, and `y_vld` and `done` feed the downstream node's sequencer, so sequencers chain exactly along netlist edges.

## Interface
Parameters:
- `FILL_CYCLES`, default 16: cycles each inlet valve is open; 0 is treated as 1.
- `MIX_ROTATIONS`, default 8: full pump rotations in MIX; 0 is treated as 1.
- `PUMP_DIV`, default 4: clock cycles per pump step; 0 is treated as 1.
- `DRAIN_CYCLES`, default 16: cycles the outlet valve is open; 0 is treated as 1.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request one mix operation; level-sampled in IDLE only.
- `a_vld` in 1: fluid available at inlet a (upstream `y_vld`).
- `b_vld` in 1: fluid available at inlet b.
- `y_rdy` in 1: downstream inlet can accept fluid.
- `v_a` out 1: inlet-a valve open.
- `v_b` out 1: inlet-b valve open.
- `v_y` out 1: outlet valve open.
- `pump` out 3: ring pump valve pattern.
- `y_vld` out 1: fluid presented at outlet; equals `v_y`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, FILL_A, FILL_B, MIX, WAIT_Y, DRAIN, DONE.
- IDLE:
  - All outputs are 0.
  - `start`=1 moves to FILL_A next cycle.
  - `start` in any other state is ignored.
- FILL_A:
  - `v_a` equals `a_vld`.
  - The fill counter increments only in cycles where `a_vld`=1.
  - On the cycle the count reaches FILL_CYCLES, the block goes to FILL_B and the counter clears.
  - A dropped `a_vld` pauses the fill; it does not restart it.
- FILL_B: same as FILL_A, using `b_vld` and `v_b`; exits to MIX.
- MIX:
  - `pump` steps 100, 110, 010, 011, 001, 101, then repeats.
  - Each step is held PUMP_DIV cycles.
  - The step index is 0 (100) on the first MIX cycle.
  - Duration is exactly MIX_ROTATIONS×6×PUMP_DIV cycles.
  - At the end, the block goes to DRAIN if `y_rdy`=1 that cycle, otherwise to WAIT_Y.
- WAIT_Y:
  - `pump`=000 and all valves are closed.
  - `y_rdy`=1 moves to DRAIN next cycle.
- DRAIN:
  - `v_y`=`y_vld`=1.
  - `pump` restarts at step 0 and runs as in MIX.
  - Lasts DRAIN_CYCLES cycles, ignoring `y_rdy`; the downstream is committed once the drain begins.
  - Exits to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in FILL_A through DRAIN; `busy`=0 in IDLE and DONE.
- Valve exclusion invariant: at most one of `v_a`, `v_b`, `v_y` is 1 in any cycle.
- Counters:
  - 16-bit fill/drain counter, 16-bit step-cycle counter, 3-bit step index, 16-bit rotation counter.
  - Parameters must fit in 16 bits.
  - The step index wraps 5→0, and the rotation counter increments on that wrap.

## Timing
- All outputs are registered from state and counters, so there is no combinational path from inputs to outputs, except `v_a`/`v_b`, which follow `a_vld`/`b_vld` combinationally while in FILL_A/FILL_B.
- With all inputs continuously high, and `start` sampled at edge 0:
  - FILL_A: cycles 1..F
  - FILL_B: cycles F+1..2F
  - MIX: next 6·R·P cycles
  - DRAIN: next D cycles
  - `done`: the following cycle
- Reset mid-operation: all outputs go to 0 and the state to IDLE immediately (asynchronously), and all counters clear. No partial-drain completion and no `done` pulse.
- `start` held high through DONE begins a new operation on the cycle after DONE (IDLE lasts 1 cycle).

## Configuration
- Macro: `MIXER_VALVE_SEQ_ABORT_EN`.
- When defined, adds:
  - Input `abort` (1 bit).
  - Outputs `v_waste` (1 bit) and `aborted` (1 bit).
  - State FLUSH.
- `abort`=1 in FILL_A, FILL_B, MIX or WAIT_Y moves to FLUSH next cycle.
  - FLUSH: `v_waste`=1, pump running from step 0, DRAIN_CYCLES long, then DONE.
  - `aborted`=1 in DONE only when that DONE followed FLUSH.
- `abort` is ignored in IDLE, DRAIN, FLUSH and DONE.
- When not defined, these ports and the FLUSH state do not exist and behaviour is as above.

## Test plan
Parameters unless stated: F=4, R=2, P=2, D=3.
- Reset: assert `rst` mid-MIX → all outputs 0 in the same cycle; `busy`=0; no `done` pulse after release.
- Nominal run: `start` pulse with `a_vld`, `b_vld`, `y_rdy` held 1 →
  - `v_a` on cycles 1–4, `v_b` on cycles 5–8;
  - `pump` 100,100,110,110,… over cycles 9–32;
  - `v_y` on cycles 33–35, `done` on cycle 36.
- Inlet stall: `a_vld` low on cycles 2–3 → `v_a` low on those cycles; FILL_A ends after cycle 6; `done` on cycle 38.
- Backpressure: `y_rdy`=0 until cycle 40 → WAIT_Y on cycles 33–40 with `pump`=000; DRAIN on cycles 41–43; `done` on cycle 44.
- Zero parameters: F=R=P=D=0 → behaves as 1; FILL_A 1, FILL_B 1, MIX 6 and DRAIN 1 cycles; `done` on cycle 10.
- Abort (macro defined): `abort` on cycle 12 → FLUSH on cycles 13–15 with `v_waste`=1 and `v_y`=0; `done`=`aborted`=1 on cycle 16.

Source files
------------

// File: rtl/mixer_valve_seq.sv
// mixer_valve_seq: valve/pump sequencer for one rotary mixer node.
// Fills the ring from inlet a, then inlet b, mixes for a fixed number of
// pump rotations and drains to outlet y once the downstream node is ready.
// Optional feature macro: MIXER_VALVE_SEQ_ABORT_EN adds abort/flush to waste.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, everything closed
// S_FILL_A | inlet a open while a_vld, counting filled cycles
// S_FILL_B | inlet b open while b_vld, counting filled cycles
// S_MIX    | pump cycling, MIX_ROTATIONS full rotations
// S_WAIT_Y | mix finished, waiting for downstream y_rdy
// S_DRAIN  | outlet open, pump cycling, DRAIN_CYCLES long
// S_DONE   | one-cycle completion pulse
// S_FLUSH  | (abort build) waste valve open, pump cycling, DRAIN_CYCLES long

module mixer_valve_seq #(
    parameter int FILL_CYCLES   = 16,
    parameter int MIX_ROTATIONS = 8,
    parameter int PUMP_DIV      = 4,
    parameter int DRAIN_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       a_vld,
    input  logic       b_vld,
    input  logic       y_rdy,
`ifdef MIXER_VALVE_SEQ_ABORT_EN
    input  logic       abort,
    output logic       v_waste,
    output logic       aborted,
`endif
    output logic       v_a,
    output logic       v_b,
    output logic       v_y,
    output logic [2:0] pump,
    output logic       y_vld,
    output logic       busy,
    output logic       done
);

    // Zero-valued parameters behave as 1 so every phase lasts at least a cycle.
    localparam logic [15:0] F_EFF = (FILL_CYCLES   == 0) ? 16'd1 : 16'(FILL_CYCLES);
    localparam logic [15:0] R_EFF = (MIX_ROTATIONS == 0) ? 16'd1 : 16'(MIX_ROTATIONS);
    localparam logic [15:0] P_EFF = (PUMP_DIV      == 0) ? 16'd1 : 16'(PUMP_DIV);
    localparam logic [15:0] D_EFF = (DRAIN_CYCLES  == 0) ? 16'd1 : 16'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_A,
        S_FILL_B,
        S_MIX,
        S_WAIT_Y,
        S_DRAIN,
        S_DONE
`ifdef MIXER_VALVE_SEQ_ABORT_EN
        , S_FLUSH
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] sc_q, sc_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] rot_q, rot_d;
    logic        v_y_q, v_y_d;
    logic [2:0]  pump_q, pump_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef MIXER_VALVE_SEQ_ABORT_EN
    logic        v_waste_q, v_waste_d;
    logic        aborted_q, aborted_d;
`endif

    logic pumping;
    logic step_wrap;
    logic mix_end;
    logic fill_end;
    logic drain_end;

    function automatic logic [2:0] pump_pat(input logic [2:0] idx);
        case (idx)
            3'd0:    pump_pat = 3'b100;
            3'd1:    pump_pat = 3'b110;
            3'd2:    pump_pat = 3'b010;
            3'd3:    pump_pat = 3'b011;
            3'd4:    pump_pat = 3'b001;
            3'd5:    pump_pat = 3'b101;
            default: pump_pat = 3'b000;
        endcase
    endfunction

`ifdef MIXER_VALVE_SEQ_ABORT_EN
    assign pumping = (state_q == S_MIX) || (state_q == S_DRAIN) || (state_q == S_FLUSH);
`else
    assign pumping = (state_q == S_MIX) || (state_q == S_DRAIN);
`endif
    assign step_wrap = (sc_q + 16'd1) == P_EFF;
    assign mix_end   = step_wrap && (idx_q == 3'd5) && ((rot_q + 16'd1) == R_EFF);
    assign fill_end  = (cnt_q + 16'd1) == F_EFF;
    assign drain_end = (cnt_q + 16'd1) == D_EFF;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sc_d    = sc_q;
        idx_d   = idx_q;
        rot_d   = rot_q;

        if (pumping) begin
            if (step_wrap) begin
                sc_d = '0;
                if (idx_q == 3'd5) begin
                    idx_d = '0;
                    rot_d = rot_q + 16'd1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end else begin
                sc_d = sc_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL_A;
                    cnt_d   = '0;
                end
            end
            S_FILL_A: begin
                if (a_vld) begin
                    if (fill_end) begin
                        state_d = S_FILL_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_FILL_B: begin
                if (b_vld) begin
                    if (fill_end) begin
                        state_d = S_MIX;
                        cnt_d   = '0;
                        sc_d    = '0;
                        idx_d   = '0;
                        rot_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_MIX: begin
                if (mix_end) begin
                    state_d = y_rdy ? S_DRAIN : S_WAIT_Y;
                    cnt_d   = '0;
                    sc_d    = '0;
                    idx_d   = '0;
                    rot_d   = '0;
                end
            end
            S_WAIT_Y: begin
                if (y_rdy) begin
                    state_d = S_DRAIN;
                end
            end
`ifdef MIXER_VALVE_SEQ_ABORT_EN
            S_DRAIN, S_FLUSH: begin
`else
            S_DRAIN: begin
`endif
                if (drain_end) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MIXER_VALVE_SEQ_ABORT_EN
        if (abort && ((state_q == S_FILL_A) || (state_q == S_FILL_B) ||
                      (state_q == S_MIX) || (state_q == S_WAIT_Y))) begin
            state_d = S_FLUSH;
            cnt_d   = '0;
            sc_d    = '0;
            idx_d   = '0;
            rot_d   = '0;
        end
`endif

        // Outputs are registered, so they are derived from the next state.
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
        v_y_d  = (state_d == S_DRAIN);
        pump_d = 3'b000;
        case (state_d)
`ifdef MIXER_VALVE_SEQ_ABORT_EN
            S_MIX, S_DRAIN, S_FLUSH: pump_d = pump_pat(idx_d);
`else
            S_MIX, S_DRAIN:          pump_d = pump_pat(idx_d);
`endif
            default:                 pump_d = 3'b000;
        endcase
`ifdef MIXER_VALVE_SEQ_ABORT_EN
        v_waste_d = (state_d == S_FLUSH);
        aborted_d = (state_d == S_DONE) && (state_q == S_FLUSH);
`endif
    end

    // State, counters and registered outputs; reset forces everything idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sc_q      <= '0;
            idx_q     <= '0;
            rot_q     <= '0;
            v_y_q     <= 1'b0;
            pump_q    <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MIXER_VALVE_SEQ_ABORT_EN
            v_waste_q <= 1'b0;
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sc_q      <= sc_d;
            idx_q     <= idx_d;
            rot_q     <= rot_d;
            v_y_q     <= v_y_d;
            pump_q    <= pump_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MIXER_VALVE_SEQ_ABORT_EN
            v_waste_q <= v_waste_d;
            aborted_q <= aborted_d;
`endif
        end
    end

    // Inlet valves track their supply directly so a stalled upstream closes them at once.
    assign v_a   = (state_q == S_FILL_A) && a_vld;
    assign v_b   = (state_q == S_FILL_B) && b_vld;
    assign v_y   = v_y_q;
    assign y_vld = v_y_q;
    assign pump  = pump_q;
    assign busy  = busy_q;
    assign done  = done_q;
`ifdef MIXER_VALVE_SEQ_ABORT_EN
    assign v_waste = v_waste_q;
    assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_mixer_valve_seq.sv
// Testbench for mixer_valve_seq: scoreboard of expected per-cycle outputs
// produced by a phase-level model, checked by an independent monitor.
module tb_mixer_valve_seq;

    localparam int F    = 4;
    localparam int R    = 2;
    localparam int P    = 2;
    localparam int D    = 3;
    localparam int MAXR = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, a_vld, b_vld, y_rdy;
    logic       v_a, v_b, v_y, y_vld, busy, done;
    logic [2:0] pump;
`ifdef MIXER_VALVE_SEQ_ABORT_EN
    logic       abort, v_waste, aborted;
`endif

    logic       one = 1'b1;
    logic       z_start;
    logic       z_v_a, z_v_b, z_v_y, z_y_vld, z_busy, z_done;
    logic [2:0] z_pump;
`ifdef MIXER_VALVE_SEQ_ABORT_EN
    logic       z_abort, z_v_waste, z_aborted;
`endif

    mixer_valve_seq #(.FILL_CYCLES(F), .MIX_ROTATIONS(R), .PUMP_DIV(P), .DRAIN_CYCLES(D)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a_vld(a_vld), .b_vld(b_vld), .y_rdy(y_rdy),
`ifdef MIXER_VALVE_SEQ_ABORT_EN
        .abort(abort), .v_waste(v_waste), .aborted(aborted),
`endif
        .v_a(v_a), .v_b(v_b), .v_y(v_y), .pump(pump), .y_vld(y_vld), .busy(busy), .done(done)
    );

    mixer_valve_seq #(.FILL_CYCLES(0), .MIX_ROTATIONS(0), .PUMP_DIV(0), .DRAIN_CYCLES(0)) u_zero (
        .clk(clk), .rst(rst), .start(z_start), .a_vld(one), .b_vld(one), .y_rdy(one),
`ifdef MIXER_VALVE_SEQ_ABORT_EN
        .abort(z_abort), .v_waste(z_v_waste), .aborted(z_aborted),
`endif
        .v_a(z_v_a), .v_b(z_v_b), .v_y(z_v_y), .pump(z_pump), .y_vld(z_y_vld), .busy(z_busy), .done(z_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         gcyc     = 0;
    int         last_done = -1;
    bit         mon_en   = 1'b0;
    bit         a_arr [MAXR];
    bit         b_arr [MAXR];
    bit         y_arr [MAXR];
    bit         hold;
    logic [2:0] pat_tbl [6];

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, gcyc);
        end
    endtask

    function automatic void push(input int c, input logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endfunction

    // Phase-level reference: vector = {v_a, v_b, v_y, pump, busy, done}.
    task automatic model_push(input int s0, output int len);
        int r;
        int cnt;
        r = 1;
        cnt = 0;
        while (cnt < F) begin
            push(s0 + r, {a_arr[r], 1'b0, 1'b0, 3'b000, 1'b1, 1'b0});
            if (a_arr[r]) cnt++;
            r++;
        end
        cnt = 0;
        while (cnt < F) begin
            push(s0 + r, {1'b0, b_arr[r], 1'b0, 3'b000, 1'b1, 1'b0});
            if (b_arr[r]) cnt++;
            r++;
        end
        for (int k = 0; k < 6 * R * P; k++) begin
            push(s0 + r, {3'b000, pat_tbl[(k / P) % 6], 1'b1, 1'b0});
            r++;
        end
        if (!y_arr[r - 1]) begin
            while (1) begin
                push(s0 + r, {3'b000, 3'b000, 1'b1, 1'b0});
                r++;
                if (y_arr[r - 1]) break;
            end
        end
        for (int k = 0; k < D; k++) begin
            push(s0 + r, {2'b00, 1'b1, pat_tbl[(k / P) % 6], 1'b1, 1'b0});
            r++;
        end
        push(s0 + r, 8'b0000_0001);
        len = r;
    endtask

    // Monitor: pops an expected vector whenever the DUT shows activity.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [7:0] act;
            exp_t       e;
            act = {v_a, v_b, v_y, pump, busy, done};
            if (busy || done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", int'(act), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_cycle", gcyc, e.cyc);
                    chk($sformatf("out_vec@%0d", e.cyc), int'(act), int'(e.vec));
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= gcyc) begin
                e = exp_q.pop_front();
                chk($sformatf("missing_out@%0d", e.cyc), int'(act), int'(e.vec));
            end else begin
                chk("idle_outputs", int'(act), 0);
            end
            chk("y_vld_eq_v_y", int'(y_vld), int'(v_y));
            chk("valve_excl", int'(v_a) + int'(v_b) + int'(v_y) <= 1 ? 1 : 0, 1);
            if (done) last_done = gcyc;
        end
    end

    task automatic run_op(input int exp_rel);
        int s0;
        int len;
        @(posedge clk); #1;
        s0 = gcyc;
        model_push(s0, len);
        for (int r = 0; r <= len; r++) begin
            if (r > 0) begin
                @(posedge clk); #1;
            end
            start = (r == 0) || hold;
            a_vld = a_arr[r];
            b_vld = b_arr[r];
            y_rdy = y_arr[r];
        end
        @(negedge clk); #1;
        chk("done_rel_model", last_done - s0, len);
        if (exp_rel >= 0) chk("done_rel_spec", last_done - s0, exp_rel);
        if (!hold) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                start = 1'b0;
                a_vld = 1'($urandom_range(0, 1));
                b_vld = 1'($urandom_range(0, 1));
                y_rdy = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic fill_all_high();
        for (int r = 0; r < MAXR; r++) begin
            a_arr[r] = 1'b1;
            b_arr[r] = 1'b1;
            y_arr[r] = 1'b1;
        end
        hold = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done, n_busy, zn_a, zn_b, zn_y, zn_mix, z_done_rel;
        pat_tbl = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        rst = 1'b1; start = 1'b0; a_vld = 1'b0; b_vld = 1'b0; y_rdy = 1'b0; z_start = 1'b0;
`ifdef MIXER_VALVE_SEQ_ABORT_EN
        abort = 1'b0; z_abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({v_a, v_b, v_y, pump, y_vld, busy, done}), 0);
        rst = 1'b0;

        // Reset in the middle of MIX.
        @(posedge clk); #1;
        start = 1'b1; a_vld = 1'b1; b_vld = 1'b1; y_rdy = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("mid_mix_busy", int'(busy), 1);
        chk("mid_mix_pump", int'(pump), 3'b110);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({v_a, v_b, v_y, pump, y_vld, busy, done}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0; n_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("no_done_after_reset", n_done, 0);
        chk("no_busy_after_reset", n_busy, 0);

        mon_en = 1'b1;

        fill_all_high();
        run_op(36);

        fill_all_high();
        a_arr[2] = 1'b0; a_arr[3] = 1'b0;
        run_op(38);

        fill_all_high();
        for (int r = 0; r < 40; r++) y_arr[r] = 1'b0;
        run_op(44);

        // start held through DONE: next op follows back-to-back.
        fill_all_high();
        hold = 1'b1;
        run_op(36);
        hold = 1'b0;
        run_op(36);

        for (int n = 0; n < 16; n++) begin
            for (int r = 0; r < MAXR; r++) begin
                a_arr[r] = (r >= 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
                b_arr[r] = (r >= 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
                y_arr[r] = (r >= 80) ? 1'b1 : ($urandom_range(0, 1) != 0);
            end
            hold = ($urandom_range(0, 3) == 0);
            run_op(-1);
        end
        hold = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        // Zero-valued parameters on the second instance.
        zn_a = 0; zn_b = 0; zn_y = 0; zn_mix = 0; z_done_rel = -1;
        @(posedge clk); #1;
        z_start = 1'b1;
        for (int r = 1; r <= 14; r++) begin
            @(posedge clk); #1;
            z_start = 1'b0;
            @(negedge clk);
            if (z_v_a) zn_a++;
            if (z_v_b) zn_b++;
            if (z_v_y && z_y_vld) zn_y++;
            if (z_busy && !z_v_a && !z_v_b && !z_v_y && z_pump != 3'b000) zn_mix++;
            if (z_done) z_done_rel = r;
        end
        chk("zero_fill_a", zn_a, 1);
        chk("zero_fill_b", zn_b, 1);
        chk("zero_mix", zn_mix, 6);
        chk("zero_drain", zn_y, 1);
        chk("zero_done_rel", z_done_rel, 10);

`ifdef MIXER_VALVE_SEQ_ABORT_EN
        mon_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a_vld = 1'b1; b_vld = 1'b1; y_rdy = 1'b1;
        for (int r = 1; r <= 20; r++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = (r == 12);
            @(negedge clk);
            if (r >= 13 && r <= 15) begin
                chk("flush_waste", int'(v_waste), 1);
                chk("flush_no_v_y", int'(v_y), 0);
            end
            if (r == 16) chk("abort_done_aborted", int'({done, aborted}), 3);
        end
        abort = 1'b0;
        mon_en = 1'b1;
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
